// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// State encoding, NOP and default vectors.
package fetch_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/fetch_sequencer_next_pc_sel.sv
// next_pc_sel: priority select trap > redirect > +4.
// Ports: trap_i, redir_i, target_i, seq_i, pc_i -> next_pc_o, mis_o.
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter int unsigned       DWIDTH      = 32,
  parameter logic [DWIDTH-1:0] TRAP_VECTOR =
    DWIDTH'(DEF_TRAP_VECTOR)
) (
  input  logic              trap_i,
  input  logic              redir_i,
  input  logic [DWIDTH-1:0] target_i,
  input  logic              seq_i,
  input  logic [DWIDTH-1:0] pc_i,
  output logic [DWIDTH-1:0] next_pc_o,
  output logic              mis_o
);

  logic tgt_mis;

  assign tgt_mis = (target_i[1:0] != 2'b00);

  // A trap wins over a misaligned redirect, so no fault then.
  assign mis_o = redir_i && !trap_i && tgt_mis;

  always_comb begin
    next_pc_o = pc_i;
    priority case (1'b1)
      trap_i:  next_pc_o = TRAP_VECTOR;
      redir_i: next_pc_o = tgt_mis ? TRAP_VECTOR
                                   : target_i;
      seq_i:   next_pc_o = pc_i + DWIDTH'(4);
      default: next_pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch PC, imem request sequencing, decode register.
// Ports: core ctl (Run/Step/Stall/redirect/trap), imem req/ack, Fetch_*.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned       DWIDTH       = 32,
  parameter logic [DWIDTH-1:0] RESET_VECTOR =
    DWIDTH'(DEF_RESET_VECTOR),
  parameter logic [DWIDTH-1:0] TRAP_VECTOR  =
    DWIDTH'(DEF_TRAP_VECTOR)
) (
  input  logic              Clk_Core,
  input  logic              Rst_Core,
  input  logic              Run,
  input  logic              Step,
  input  logic              Stall,
  input  logic              Redirect_Valid,
  input  logic [DWIDTH-1:0] Redirect_Target,
  input  logic              Trap_Valid,
  output logic              Imem_Req,
  output logic [DWIDTH-1:0] Imem_Addr,
  input  logic              Imem_Ack,
  input  logic [31:0]       Imem_Rdata,
  output logic              Fetch_Valid,
  output logic [DWIDTH-1:0] Fetch_Pc,
  output logic [31:0]       Fetch_Instr,
  output logic [DWIDTH-1:0] Program_Count,
  output logic              Halted,
  output logic              Misaligned_Fault
);

  fetch_state_t state_q, state_d;

  logic [DWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] drain_q, drain_d;
  logic [DWIDTH-1:0] fpc_q, fpc_d;
  logic [31:0]       instr_q, instr_d;
  logic              os_q, os_d;
  logic              fv_q, fv_d;
  logic              mis_q, mis_d;

  logic flush;
  logic req;
  logic ack_f;
  logic seq;

  assign flush = Trap_Valid | Redirect_Valid;

  always_comb begin
    req = 1'b0;
    unique case (state_q)
      HALT:    req = 1'b0;
      FETCH:   req = !(fv_q && Stall);
      DRAIN:   req = 1'b1;
      default: req = 1'b0;
    endcase
  end

  // Only an ack in FETCH delivers an instruction.
  assign ack_f = (state_q == FETCH) && req && Imem_Ack;
  assign seq   = ack_f && !flush;

  next_pc_sel #(
    .DWIDTH      (DWIDTH),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_next_pc_sel (
    .trap_i    (Trap_Valid),
    .redir_i   (Redirect_Valid),
    .target_i  (Redirect_Target),
    .seq_i     (seq),
    .pc_i      (pc_q),
    .next_pc_o (pc_d),
    .mis_o     (mis_d)
  );

  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    drain_d = drain_q;
    unique case (state_q)
      HALT: begin
        if (Run) begin
          state_d = FETCH;
        end else if (Step) begin
          state_d = FETCH;
          os_d    = 1'b1;
        end
      end
      FETCH: begin
        if (flush && req && !Imem_Ack) begin
          // Outstanding request must finish at its old address.
          state_d = DRAIN;
          drain_d = pc_q;
        end else if (ack_f && flush) begin
          // Data dropped; a one-shot retries at the new PC.
          if (!Run && !os_q) state_d = HALT;
        end else if (ack_f) begin
          if (!Run || os_q) begin
            state_d = HALT;
            os_d    = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (Imem_Ack) begin
          if (!Run && !os_q) state_d = HALT;
          else               state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    fv_d    = fv_q;
    fpc_d   = fpc_q;
    instr_d = instr_q;
    if (flush) begin
      fv_d = 1'b0;
    end else if (ack_f) begin
      fv_d    = 1'b1;
      fpc_d   = pc_q;
      instr_d = Imem_Rdata;
    end else if (fv_q && !Stall) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_q <= HALT;
      pc_q    <= RESET_VECTOR;
      drain_q <= RESET_VECTOR;
      fpc_q   <= '0;
      instr_q <= NOP_INSTR;
      os_q    <= 1'b0;
      fv_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drain_q <= drain_d;
      fpc_q   <= fpc_d;
      instr_q <= instr_d;
      os_q    <= os_d;
      fv_q    <= fv_d;
      mis_q   <= mis_d;
    end
  end

  assign Imem_Req         = req;
  assign Imem_Addr        = (state_q == DRAIN) ? drain_q : pc_q;
  assign Fetch_Valid      = fv_q;
  assign Fetch_Pc         = fpc_q;
  assign Fetch_Instr      = instr_q;
  assign Program_Count    = pc_q;
  assign Halted           = (state_q == HALT);
  assign Misaligned_Fault = mis_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer.
// Memory data is address ^ 32'hA5A5_0000.
module tb_fetch_sequencer;

  logic        Clk_Core = 1'b0;
  logic        Rst_Core;
  logic        Run;
  logic        Step;
  logic        Stall;
  logic        Redirect_Valid;
  logic [31:0] Redirect_Target;
  logic        Trap_Valid;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ack;
  logic [31:0] Imem_Rdata;
  logic        Fetch_Valid;
  logic [31:0] Fetch_Pc;
  logic [31:0] Fetch_Instr;
  logic [31:0] Program_Count;
  logic        Halted;
  logic        Misaligned_Fault;

  logic zw;
  logic ackm;

  int total = 0;
  int bad   = 0;

  fetch_sequencer dut (
    .Clk_Core         (Clk_Core),
    .Rst_Core         (Rst_Core),
    .Run              (Run),
    .Step             (Step),
    .Stall            (Stall),
    .Redirect_Valid   (Redirect_Valid),
    .Redirect_Target  (Redirect_Target),
    .Trap_Valid       (Trap_Valid),
    .Imem_Req         (Imem_Req),
    .Imem_Addr        (Imem_Addr),
    .Imem_Ack         (Imem_Ack),
    .Imem_Rdata       (Imem_Rdata),
    .Fetch_Valid      (Fetch_Valid),
    .Fetch_Pc         (Fetch_Pc),
    .Fetch_Instr      (Fetch_Instr),
    .Program_Count    (Program_Count),
    .Halted           (Halted),
    .Misaligned_Fault (Misaligned_Fault)
  );

  always #5 Clk_Core = ~Clk_Core;

  assign Imem_Ack   = zw ? Imem_Req : ackm;
  assign Imem_Rdata = Imem_Addr ^ 32'hA5A5_0000;

  task automatic cyc();
    @(posedge Clk_Core);
    #1;
  endtask

  task automatic test_reset();
    Rst_Core = 1'b0;
    @(negedge Clk_Core);
    if (Program_Count !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", Program_Count); end total++;
    if (Halted !== 1'b1) begin bad++; $display("FAIL rst_halted got=%b exp=1", Halted); end total++;
    if (Imem_Req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", Imem_Req); end total++;
    if (Imem_Addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", Imem_Addr); end total++;
    if (Fetch_Valid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b exp=0", Fetch_Valid); end total++;
    if (Fetch_Instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=13", Fetch_Instr); end total++;
    if (Misaligned_Fault !== 1'b0) begin bad++; $display("FAIL rst_mis got=%b exp=0", Misaligned_Fault); end total++;
  endtask

  task automatic test_stream();
    zw  = 1'b1;
    Run = 1'b1;
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk_Core);
      if (Imem_Req !== 1'b1) begin bad++; $display("FAIL stream_req[%0d] got=%b exp=1", i, Imem_Req); end total++;
      if (Imem_Addr !== 32'(4 * i)) begin bad++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, Imem_Addr, 32'(4 * i)); end total++;
      if (i == 0) begin
        if (Fetch_Valid !== 1'b0) begin bad++; $display("FAIL stream_fv0 got=%b exp=0", Fetch_Valid); end total++;
      end else begin
        if (Fetch_Valid !== 1'b1) begin bad++; $display("FAIL stream_fv[%0d] got=%b exp=1", i, Fetch_Valid); end total++;
        if (Fetch_Pc !== 32'(4 * (i - 1))) begin bad++; $display("FAIL stream_fpc[%0d] got=%h exp=%h", i, Fetch_Pc, 32'(4 * (i - 1))); end total++;
        if (Fetch_Instr !== (32'(4 * (i - 1)) ^ 32'hA5A5_0000)) begin bad++; $display("FAIL stream_instr[%0d] got=%h", i, Fetch_Instr); end total++;
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk_Core);
      if (Imem_Req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b exp=0", k, Imem_Req); end total++;
      if (Fetch_Valid !== 1'b1) begin bad++; $display("FAIL stall_fv[%0d] got=%b exp=1", k, Fetch_Valid); end total++;
      if (Fetch_Pc !== 32'hC) begin bad++; $display("FAIL stall_fpc[%0d] got=%h exp=c", k, Fetch_Pc); end total++;
      if (Fetch_Instr !== 32'hA5A5_000C) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=a5a5000c", k, Fetch_Instr); end total++;
      cyc();
    end
    Stall = 1'b0;
    @(negedge Clk_Core);
    if (Imem_Addr !== 32'h10) begin bad++; $display("FAIL stall_resume_addr got=%h exp=10", Imem_Addr); end total++;
    if (Imem_Req !== 1'b1) begin bad++; $display("FAIL stall_resume_req got=%b exp=1", Imem_Req); end total++;
    cyc();
    @(negedge Clk_Core);
    if (Fetch_Pc !== 32'h10) begin bad++; $display("FAIL stall_next_fpc got=%h exp=10", Fetch_Pc); end total++;
    if (Imem_Addr !== 32'h14) begin bad++; $display("FAIL stall_next_addr got=%h exp=14", Imem_Addr); end total++;
  endtask

  task automatic test_redirect_drain();
    Run = 1'b0;
    cyc();
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h10;
    @(negedge Clk_Core);
    if (Halted !== 1'b1) begin bad++; $display("FAIL halt_after_run0 got=%b exp=1", Halted); end total++;
    cyc();
    Redirect_Valid = 1'b0;
    zw   = 1'b0;
    ackm = 1'b0;
    Run  = 1'b1;
    @(negedge Clk_Core);
    if (Imem_Req !== 1'b0) begin bad++; $display("FAIL halt_redir_req got=%b exp=0", Imem_Req); end total++;
    if (Program_Count !== 32'h10) begin bad++; $display("FAIL halt_redir_pc got=%h exp=10", Program_Count); end total++;
    cyc();
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h200;
    @(negedge Clk_Core);
    if (Imem_Addr !== 32'h10) begin bad++; $display("FAIL drain_req_addr got=%h exp=10", Imem_Addr); end total++;
    cyc();
    Redirect_Valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge Clk_Core);
      if (Imem_Req !== 1'b1) begin bad++; $display("FAIL drain_req[%0d] got=%b exp=1", k, Imem_Req); end total++;
      if (Imem_Addr !== 32'h10) begin bad++; $display("FAIL drain_addr[%0d] got=%h exp=10", k, Imem_Addr); end total++;
      if (Program_Count !== 32'h200) begin bad++; $display("FAIL drain_pc[%0d] got=%h exp=200", k, Program_Count); end total++;
      if (Fetch_Valid !== 1'b0) begin bad++; $display("FAIL drain_fv[%0d] got=%b exp=0", k, Fetch_Valid); end total++;
      cyc();
    end
    ackm = 1'b1;
    @(negedge Clk_Core);
    if (Imem_Addr !== 32'h10) begin bad++; $display("FAIL drain_ack_addr got=%h exp=10", Imem_Addr); end total++;
    cyc();
    ackm = 1'b0;
    zw   = 1'b1;
    @(negedge Clk_Core);
    if (Fetch_Valid !== 1'b0) begin bad++; $display("FAIL drain_drop_fv got=%b exp=0", Fetch_Valid); end total++;
    if (Imem_Addr !== 32'h200) begin bad++; $display("FAIL redir_addr got=%h exp=200", Imem_Addr); end total++;
    if (Imem_Req !== 1'b1) begin bad++; $display("FAIL redir_req got=%b exp=1", Imem_Req); end total++;
    cyc();
    @(negedge Clk_Core);
    if (Fetch_Pc !== 32'h200) begin bad++; $display("FAIL redir_fpc got=%h exp=200", Fetch_Pc); end total++;
    if (Fetch_Instr !== 32'hA5A5_0200) begin bad++; $display("FAIL redir_instr got=%h exp=a5a50200", Fetch_Instr); end total++;
  endtask

  task automatic test_misaligned();
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h202;
    cyc();
    Redirect_Valid = 1'b0;
    @(negedge Clk_Core);
    if (Misaligned_Fault !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b exp=1", Misaligned_Fault); end total++;
    if (Fetch_Valid !== 1'b0) begin bad++; $display("FAIL mis_flush_fv got=%b exp=0", Fetch_Valid); end total++;
    if (Imem_Addr !== 32'h100) begin bad++; $display("FAIL mis_addr got=%h exp=100", Imem_Addr); end total++;
    cyc();
    @(negedge Clk_Core);
    if (Misaligned_Fault !== 1'b0) begin bad++; $display("FAIL mis_end got=%b exp=0", Misaligned_Fault); end total++;
    if (Fetch_Pc !== 32'h100) begin bad++; $display("FAIL mis_fpc got=%h exp=100", Fetch_Pc); end total++;
    Trap_Valid      = 1'b1;
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h302;
    cyc();
    Trap_Valid     = 1'b0;
    Redirect_Valid = 1'b0;
    @(negedge Clk_Core);
    if (Misaligned_Fault !== 1'b0) begin bad++; $display("FAIL trap_nofault got=%b exp=0", Misaligned_Fault); end total++;
    if (Imem_Addr !== 32'h100) begin bad++; $display("FAIL trap_addr got=%h exp=100", Imem_Addr); end total++;
    if (Fetch_Valid !== 1'b0) begin bad++; $display("FAIL trap_fv got=%b exp=0", Fetch_Valid); end total++;
  endtask

  task automatic test_step();
    Run = 1'b0;
    cyc();
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h40;
    @(negedge Clk_Core);
    if (Program_Count !== 32'h104) begin bad++; $display("FAIL step_pre_pc got=%h exp=104", Program_Count); end total++;
    cyc();
    Redirect_Valid = 1'b0;
    Step = 1'b1;
    @(negedge Clk_Core);
    if (Halted !== 1'b1) begin bad++; $display("FAIL step_halted got=%b exp=1", Halted); end total++;
    if (Program_Count !== 32'h40) begin bad++; $display("FAIL step_pc got=%h exp=40", Program_Count); end total++;
    cyc();
    Step = 1'b0;
    @(negedge Clk_Core);
    if (Imem_Req !== 1'b1) begin bad++; $display("FAIL step_req got=%b exp=1", Imem_Req); end total++;
    if (Imem_Addr !== 32'h40) begin bad++; $display("FAIL step_addr got=%h exp=40", Imem_Addr); end total++;
    cyc();
    @(negedge Clk_Core);
    if (Halted !== 1'b1) begin bad++; $display("FAIL step_done_halted got=%b exp=1", Halted); end total++;
    if (Program_Count !== 32'h44) begin bad++; $display("FAIL step_done_pc got=%h exp=44", Program_Count); end total++;
    if (Fetch_Pc !== 32'h40) begin bad++; $display("FAIL step_fpc got=%h exp=40", Fetch_Pc); end total++;
    if (Imem_Req !== 1'b0) begin bad++; $display("FAIL step_once_req got=%b exp=0", Imem_Req); end total++;
    cyc();
    @(negedge Clk_Core);
    if (Imem_Req !== 1'b0) begin bad++; $display("FAIL step_once_req2 got=%b exp=0", Imem_Req); end total++;
    if (Fetch_Valid !== 1'b0) begin bad++; $display("FAIL step_fv_clear got=%b exp=0", Fetch_Valid); end total++;
  endtask

  task automatic test_wrap();
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'hFFFF_FFFC;
    cyc();
    Redirect_Valid = 1'b0;
    Step = 1'b1;
    cyc();
    Step = 1'b0;
    @(negedge Clk_Core);
    if (Imem_Addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", Imem_Addr); end total++;
    cyc();
    @(negedge Clk_Core);
    if (Program_Count !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", Program_Count); end total++;
    if (Fetch_Pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_fpc got=%h exp=fffffffc", Fetch_Pc); end total++;
  endtask

  task automatic test_reset_drain();
    zw   = 1'b0;
    ackm = 1'b0;
    Run  = 1'b1;
    cyc();
    Redirect_Valid  = 1'b1;
    Redirect_Target = 32'h80;
    cyc();
    Redirect_Valid = 1'b0;
    @(negedge Clk_Core);
    if (Imem_Req !== 1'b1) begin bad++; $display("FAIL rd_req got=%b exp=1", Imem_Req); end total++;
    if (Program_Count !== 32'h80) begin bad++; $display("FAIL rd_pc got=%h exp=80", Program_Count); end total++;
    Rst_Core = 1'b1;
    Run      = 1'b0;
    cyc();
    Rst_Core = 1'b0;
    @(negedge Clk_Core);
    if (Imem_Req !== 1'b0) begin bad++; $display("FAIL rd_rst_req got=%b exp=0", Imem_Req); end total++;
    if (Imem_Addr !== 32'h0) begin bad++; $display("FAIL rd_rst_addr got=%h exp=0", Imem_Addr); end total++;
    if (Program_Count !== 32'h0) begin bad++; $display("FAIL rd_rst_pc got=%h exp=0", Program_Count); end total++;
    if (Halted !== 1'b1) begin bad++; $display("FAIL rd_rst_halted got=%b exp=1", Halted); end total++;
    if (Fetch_Pc !== 32'h0) begin bad++; $display("FAIL rd_rst_fpc got=%h exp=0", Fetch_Pc); end total++;
    if (Fetch_Instr !== 32'h13) begin bad++; $display("FAIL rd_rst_instr got=%h exp=13", Fetch_Instr); end total++;
    if (Fetch_Valid !== 1'b0) begin bad++; $display("FAIL rd_rst_fv got=%b exp=0", Fetch_Valid); end total++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst_Core        = 1'b1;
    Run             = 1'b0;
    Step            = 1'b0;
    Stall           = 1'b0;
    Redirect_Valid  = 1'b0;
    Redirect_Target = 32'h0;
    Trap_Valid      = 1'b0;
    zw              = 1'b0;
    ackm            = 1'b0;
    cyc();
    cyc();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drain();
    test_misaligned();
    test_step();
    test_wrap();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
